call_stack_ctrl: RTL and testbench

Controller that sequences the return-address call stack for the CPU front end. It decodes call/return events from decode and computes the return address pushed on each call. It issues pop/push to the stack and returns a registered return-address prediction to fetch. On pipeline flush it drains the stack to empty, one pop per cycle.

---
 rtl/call_stack_ctrl_pkg.sv | 27 ++
 rtl/call_stack_ctrl_stats.sv | 52 +++++
 rtl/call_stack_ctrl.sv | 154 +++++++++++++++
 tb/tb_call_stack_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/call_stack_ctrl_pkg.sv
// rtl/call_stack_ctrl_pkg.sv - shared types and constants for the call stack controller
//
// Contents:
//   state_e      controller states (IDLE, DRAIN)
//   RA_INC_*     return-address increments for 16-bit and 32-bit call instructions
//   STAT_CNTW    default statistics counter width
//   stat_cnt_t   statistics counter type at the default width
//   ra_inc()     selects the return-address increment from the RVC flag
package call_stack_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam logic [2:0] RA_INC_RVC = 3'd2;
    localparam logic [2:0] RA_INC_STD = 3'd4;

    localparam int STAT_CNTW = 16;

    typedef logic [STAT_CNTW-1:0] stat_cnt_t;

    function automatic logic [2:0] ra_inc(input logic rvc);
        return rvc ? RA_INC_RVC : RA_INC_STD;
    endfunction

endpackage

// File: rtl/call_stack_ctrl_stats.sv
// rtl/call_stack_ctrl_stats.sv - saturating overflow/underflow event counters
//
// Ports:
//   clk, areset      clock, asynchronous active-high reset
//   i_clr            synchronous clear (controller entering DRAIN)
//   i_ovf_evt        push accepted into a full stack without a pop
//   i_unf_evt        return predicted with an empty stack
//   o_ovf_cnt        overflow count, saturates at all-ones
//   o_unf_cnt        underflow count, saturates at all-ones
module call_stack_ctrl_stats
    import call_stack_ctrl_pkg::*;
#(
    parameter int CNTW = STAT_CNTW
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            i_clr,
    input  logic            i_ovf_evt,
    input  logic            i_unf_evt,
    output logic [CNTW-1:0] o_ovf_cnt,
    output logic [CNTW-1:0] o_unf_cnt
);

    logic [CNTW-1:0] ovf_q, ovf_d;
    logic [CNTW-1:0] unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (i_clr) begin
            ovf_d = '0;
            unf_d = '0;
        end else begin
            if (i_ovf_evt && !(&ovf_q)) ovf_d = ovf_q + CNTW'(1);
            if (i_unf_evt && !(&unf_q)) unf_d = unf_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign o_ovf_cnt = ovf_q;
    assign o_unf_cnt = unf_q;

endmodule

// File: rtl/call_stack_ctrl.sv
// rtl/call_stack_ctrl.sv - return-address call stack sequencer for the CPU front end
//
// Optional feature macro: CALL_STACK_CTRL_STATS_EN (adds o_ovf_cnt / o_unf_cnt).
//
// Ports:
//   clk, areset        clock, asynchronous active-high reset
//   i_call, i_ret      decoded call / return this cycle
//   i_pc, i_rvc        PC of the event and 16-bit instruction flag
//   i_flush            pipeline flush, starts draining the stack
//   o_pred_valid       registered prediction pulse, o_pred_addr holds otherwise
//   o_pred_addr        predicted return address
//   o_pred_nohit       registered pulse: return seen with empty stack
//   o_busy             drain in progress
//   o_stk_push_en/data push request to the stack (combinational)
//   o_stk_pop_en       pop request to the stack (combinational)
//   i_stk_pop_data     current stack top
//   i_stk_full/empty   stack status flags
//   o_ovf_cnt/o_unf_cnt  statistics (macro only)
module call_stack_ctrl
    import call_stack_ctrl_pkg::*;
#(
    parameter int DPT  = 4,
    parameter int DW   = 32
`ifdef CALL_STACK_CTRL_STATS_EN
    ,
    parameter int CNTW = STAT_CNTW
`endif
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          i_call,
    input  logic          i_ret,
    input  logic [DW-1:0] i_pc,
    input  logic          i_rvc,
    input  logic          i_flush,
    output logic          o_pred_valid,
    output logic [DW-1:0] o_pred_addr,
    output logic          o_pred_nohit,
    output logic          o_busy,
    output logic          o_stk_push_en,
    output logic [DW-1:0] o_stk_push_data,
    output logic          o_stk_pop_en,
    input  logic [DW-1:0] i_stk_pop_data,
    input  logic          i_stk_full,
    input  logic          i_stk_empty
`ifdef CALL_STACK_CTRL_STATS_EN
    ,
    output logic [CNTW-1:0] o_ovf_cnt,
    output logic [CNTW-1:0] o_unf_cnt
`endif
);

    // Watchdog wide enough to hold the value DPT itself.
    localparam int WDW = $clog2(DPT) + 1;

    state_e         state_q, state_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [WDW-1:0] wd_inc;
    logic           pv_q, pv_d;
    logic [DW-1:0]  pa_q, pa_d;
    logic           nh_q, nh_d;

    logic           push_c;
    logic           pop_c;
    logic           busy_c;

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        pv_d    = 1'b0;
        pa_d    = pa_q;
        nh_d    = 1'b0;
        push_c  = 1'b0;
        pop_c   = 1'b0;
        busy_c  = 1'b0;
        wd_inc  = wd_q;

        unique case (state_q)
            IDLE: begin
                if (i_flush) begin
                    // Flush wins over any same-cycle call/return.
                    state_d = DRAIN;
                    wd_d    = '0;
                end else begin
                    push_c = i_call;
                    pop_c  = i_ret && !i_stk_empty;
                    pv_d   = pop_c;
                    nh_d   = i_ret && i_stk_empty;
                    if (pop_c) pa_d = i_stk_pop_data;
                end
            end
            DRAIN: begin
                busy_c = 1'b1;
                pop_c  = !i_stk_empty;
                wd_inc = wd_q + WDW'(pop_c);
                // The watchdog bounds the drain even if the empty flag never rises.
                if (i_stk_empty || (wd_inc == WDW'(DPT))) begin
                    state_d = IDLE;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_inc;
                end
            end
            default: begin
                state_d = IDLE;
                wd_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            wd_q    <= '0;
            pv_q    <= 1'b0;
            pa_q    <= '0;
            nh_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            pv_q    <= pv_d;
            pa_q    <= pa_d;
            nh_q    <= nh_d;
        end
    end

    assign o_busy          = busy_c;
    assign o_pred_valid    = pv_q;
    assign o_pred_addr     = pa_q;
    assign o_pred_nohit    = nh_q;
    assign o_stk_push_data = i_pc + DW'(ra_inc(i_rvc));
    // Stack-side requests stay quiet for the whole reset assertion.
    assign o_stk_push_en   = push_c && !areset;
    assign o_stk_pop_en    = pop_c && !areset;

`ifdef CALL_STACK_CTRL_STATS_EN
    call_stack_ctrl_stats #(
        .CNTW (CNTW)
    ) u_stats (
        .clk       (clk),
        .areset    (areset),
        .i_clr     ((state_q == IDLE) && i_flush),
        .i_ovf_evt (o_stk_push_en && i_stk_full && !o_stk_pop_en),
        .i_unf_evt (nh_q),
        .o_ovf_cnt (o_ovf_cnt),
        .o_unf_cnt (o_unf_cnt)
    );
`else
    // The full flag only feeds the overflow statistic.
    logic unused_stk_full;
    assign unused_stk_full = i_stk_full;
`endif

endmodule

// File: tb/tb_call_stack_ctrl.sv
// tb/tb_call_stack_ctrl.sv - self-checking bench for call_stack_ctrl with a behavioural stack model
module tb_call_stack_ctrl;

    localparam int DPT = 4;

    logic        clk = 1'b0;
    logic        areset;
    logic        i_call, i_ret, i_rvc, i_flush;
    logic [31:0] i_pc;
    logic        o_pred_valid, o_pred_nohit, o_busy;
    logic [31:0] o_pred_addr;
    logic        o_stk_push_en, o_stk_pop_en;
    logic [31:0] o_stk_push_data;
    logic [31:0] i_stk_pop_data;
    logic        i_stk_full, i_stk_empty;
`ifdef CALL_STACK_CTRL_STATS_EN
    logic [15:0] ovf_cnt, unf_cnt;
`endif

    call_stack_ctrl #(.DPT(DPT), .DW(32)) dut (
        .clk             (clk),
        .areset          (areset),
        .i_call          (i_call),
        .i_ret           (i_ret),
        .i_pc            (i_pc),
        .i_rvc           (i_rvc),
        .i_flush         (i_flush),
        .o_pred_valid    (o_pred_valid),
        .o_pred_addr     (o_pred_addr),
        .o_pred_nohit    (o_pred_nohit),
        .o_busy          (o_busy),
        .o_stk_push_en   (o_stk_push_en),
        .o_stk_push_data (o_stk_push_data),
        .o_stk_pop_en    (o_stk_pop_en),
        .i_stk_pop_data  (i_stk_pop_data),
        .i_stk_full      (i_stk_full),
        .i_stk_empty     (i_stk_empty)
`ifdef CALL_STACK_CTRL_STATS_EN
        ,
        .o_ovf_cnt       (ovf_cnt),
        .o_unf_cnt       (unf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: stack contents (last element is the top) and expected outputs.
    logic [31:0] stk[$];
    bit          m_drain = 0;
    int          m_pops = 0;
    bit          m_push_en, m_pop_en, m_busy;
    logic [31:0] m_push_data;
    bit          m_pv = 0, m_nh = 0;
    logic [31:0] m_pa = 0;
    int          m_ovf = 0, m_unf = 0;
    bit          chk_en = 0;

    // Snapshot of the combinational outputs seen in the last driven cycle.
    logic        s_push_en, s_pop_en, s_busy;
    logic [31:0] s_push_data;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("push_en", {31'd0, o_stk_push_en}, {31'd0, m_push_en});
            if (m_push_en) chk("push_data", o_stk_push_data, m_push_data);
            chk("pop_en", {31'd0, o_stk_pop_en}, {31'd0, m_pop_en});
            chk("busy", {31'd0, o_busy}, {31'd0, m_busy});
            chk("pred_valid", {31'd0, o_pred_valid}, {31'd0, m_pv});
            chk("pred_addr", o_pred_addr, m_pa);
            chk("pred_nohit", {31'd0, o_pred_nohit}, {31'd0, m_nh});
`ifdef CALL_STACK_CTRL_STATS_EN
            chk("ovf_cnt", {16'd0, ovf_cnt}, m_ovf);
            chk("unf_cnt", {16'd0, unf_cnt}, m_unf);
`endif
        end
    end

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic cycle(input bit call, input bit ret, input logic [31:0] pc,
                         input bit rvc, input bit flush);
        bit empty, full, popped;
        logic [31:0] top;
        i_call = call; i_ret = ret; i_pc = pc; i_rvc = rvc; i_flush = flush;
        empty = (stk.size() == 0);
        full  = (stk.size() == DPT);
        top   = empty ? $urandom : stk[stk.size()-1];
        i_stk_empty = empty; i_stk_full = full; i_stk_pop_data = top;

        m_busy      = m_drain;
        m_push_data = pc + (rvc ? 32'd2 : 32'd4);
        m_push_en   = !m_drain && !flush && call;
        m_pop_en    = m_drain ? !empty : (!flush && ret && !empty);

        @(negedge clk);
        s_push_en = o_stk_push_en; s_pop_en = o_stk_pop_en;
        s_busy = o_busy; s_push_data = o_stk_push_data;
        @(posedge clk);

        if (m_drain) begin
            if (m_nh && m_unf < 16'hFFFF) m_unf++;
            m_pv = 0; m_nh = 0;
            if (!empty) begin void'(stk.pop_back()); m_pops++; end
            if (empty || m_pops == DPT) m_drain = 0;
        end else if (flush) begin
            m_drain = 1; m_pops = 0; m_pv = 0; m_nh = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (m_nh && m_unf < 16'hFFFF) m_unf++;
            popped = ret && !empty;
            m_pv = popped;
            m_nh = ret && empty;
            if (popped) m_pa = top;
            if (call && full && !popped && m_ovf < 16'hFFFF) m_ovf++;
            if (popped) void'(stk.pop_back());
            if (call) begin
                if (stk.size() == DPT) void'(stk.pop_front());
                stk.push_back(m_push_data);
            end
        end
        #1;
    endtask

    task automatic idle(); cycle(0, 0, 32'h0, 0, 0); endtask
    task automatic call_at(input logic [31:0] pc, input bit rvc); cycle(1, 0, pc, rvc, 0); endtask
    task automatic ret_op(); cycle(0, 1, 32'h0, 0, 0); endtask

    task automatic model_reset();
        stk.delete();
        m_drain = 0; m_pops = 0; m_pv = 0; m_nh = 0; m_pa = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pred_valid"}, {31'd0, o_pred_valid}, 32'd0);
        chk({tag, "_pred_addr"}, o_pred_addr, 32'd0);
        chk({tag, "_pred_nohit"}, {31'd0, o_pred_nohit}, 32'd0);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_push_en"}, {31'd0, o_stk_push_en}, 32'd0);
        chk({tag, "_pop_en"}, {31'd0, o_stk_pop_en}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_n, pop_n;
        areset = 1; i_call = 1; i_ret = 0; i_pc = 32'h40; i_rvc = 0; i_flush = 0;
        i_stk_pop_data = 32'h1234; i_stk_full = 0; i_stk_empty = 1;
        #2;
        check_zero("reset");
        @(posedge clk); #1;
        i_call = 0; areset = 0; chk_en = 1;

        // Single call then return.
        call_at(32'h1000, 0);
        chk("lit_push_1004", s_push_data, 32'h1004);
        ret_op();
        chk("lit_pv_1", {31'd0, o_pred_valid}, 32'd1);
        chk("lit_pa_1004", o_pred_addr, 32'h1004);

        // Nested calls with RVC, unwinding, then one return too many.
        call_at(32'h100, 1);
        chk("lit_push_102", s_push_data, 32'h102);
        call_at(32'h200, 0);
        call_at(32'h300, 0);
        chk("lit_push_304", s_push_data, 32'h304);
        ret_op(); chk("lit_pa_304", o_pred_addr, 32'h304);
        ret_op(); chk("lit_pa_204", o_pred_addr, 32'h204);
        ret_op(); chk("lit_pa_102", o_pred_addr, 32'h102);
        ret_op();
        chk("lit_nohit_pop", {31'd0, s_pop_en}, 32'd0);
        chk("lit_nohit", {31'd0, o_pred_nohit}, 32'd1);
        chk("lit_nohit_pv", {31'd0, o_pred_valid}, 32'd0);

        // Coroutine swap and address wrap.
        call_at(32'h2000, 0);
        cycle(1, 1, 32'h3000, 0, 0);
        chk("lit_co_pop", {31'd0, s_pop_en}, 32'd1);
        chk("lit_co_push", s_push_data, 32'h3004);
        chk("lit_co_pa", o_pred_addr, 32'h2004);
        ret_op(); chk("lit_co_top", o_pred_addr, 32'h3004);
        call_at(32'hFFFF_FFFE, 1);
        chk("lit_wrap", s_push_data, 32'h0);
        ret_op();

        // Overflow: five calls into a four-deep stack.
        for (int k = 1; k <= 5; k++) call_at(32'(k * 16), 0);
`ifdef CALL_STACK_CTRL_STATS_EN
        chk("lit_ovf_cnt", {16'd0, ovf_cnt}, 32'd1);
`endif
        ret_op(); chk("lit_ovf_54", o_pred_addr, 32'h54);
        ret_op(); chk("lit_ovf_44", o_pred_addr, 32'h44);
        ret_op(); chk("lit_ovf_34", o_pred_addr, 32'h34);
        ret_op(); chk("lit_ovf_24", o_pred_addr, 32'h24);
        ret_op(); chk("lit_ovf_nohit", {31'd0, o_pred_nohit}, 32'd1);

        // Flush with three entries; the same-cycle call is dropped.
        call_at(32'h10, 0); call_at(32'h20, 0); call_at(32'h30, 0);
        cycle(1, 0, 32'h40, 0, 1);
        chk("lit_flush_drop", {31'd0, s_push_en}, 32'd0);
        busy_n = 0; pop_n = 0;
        for (int k = 0; k < 8; k++) begin
            idle();
            busy_n += int'(s_busy); pop_n += int'(s_pop_en);
        end
        chk("lit_drain_busy3", busy_n, 32'd4);
        chk("lit_drain_pops3", pop_n, 32'd3);
        ret_op(); chk("lit_drain_nohit", {31'd0, o_pred_nohit}, 32'd1);

        // Full stack drain ends on the watchdog after DPT pops.
        for (int k = 0; k < DPT; k++) call_at(32'h800 + 32'(k), 1);
        cycle(0, 0, 32'h0, 0, 1);
        busy_n = 0; pop_n = 0;
        for (int k = 0; k < 8; k++) begin
            idle();
            busy_n += int'(s_busy); pop_n += int'(s_pop_en);
        end
        chk("lit_wd_busy", busy_n, 32'(DPT));
        chk("lit_wd_pops", pop_n, 32'(DPT));

        // Reset during the second drain cycle.
        call_at(32'h10, 0); call_at(32'h20, 0); call_at(32'h30, 0);
        cycle(0, 0, 32'h0, 0, 1);
        idle();
        chk("lit_pre_rst_busy", {31'd0, o_busy}, 32'd1);
        chk_en = 0;
        #2;
        areset = 1; i_call = 1; i_ret = 1; i_stk_empty = 0;
        #1;
        check_zero("midrst");
        model_reset();
        @(posedge clk); #1;
        i_call = 0; i_ret = 0; areset = 0; chk_en = 1;
        call_at(32'h500, 0);
        chk("lit_post_rst_push", {31'd0, s_push_en}, 32'd1);
        chk("lit_post_rst_data", s_push_data, 32'h504);
        ret_op(); chk("lit_post_rst_pa", o_pred_addr, 32'h504);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            logic [31:0] r;
            r = $urandom;
            cycle(r[0], r[1], {$urandom} & 32'hFFFF_FFFE | 32'(r[2] & r[3]) << 31,
                  r[4], r[9:5] == 5'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
